// File: rtl/demux_1to2_reg.sv
// ---------------------------------------------------------------------------
// demux_1to2_reg
//   Registered 1-to-2 demultiplexer. A data word on `i` qualified by
//   `in_valid` is steered to channel A (sel=0) or channel B (sel=1) and
//   appears on the outputs one cycle later, with a one-cycle valid strobe on
//   the receiving channel. The unselected channel either clears to zero
//   (HOLD_UNSEL=0) or keeps its last word (HOLD_UNSEL=1).
//
// Parameters
//   bit_width   data width of i / out_a / out_b (>= 1)
//   HOLD_UNSEL  0: unselected channel data is cleared, 1: it is held
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous, active-high reset (clears all outputs)
//   i         in   input data word
//   sel       in   channel select: 0 -> A, 1 -> B
//   in_valid  in   input qualifier
//   out_a     out  channel A data (registered)
//   out_b     out  channel B data (registered)
//   valid_a   out  channel A new-data strobe (registered)
//   valid_b   out  channel B new-data strobe (registered)
// ---------------------------------------------------------------------------

// One output channel: a data register plus its valid strobe.
module demux_1to2_reg_chan #(
  parameter int unsigned W    = 8,
  parameter bit          HOLD = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_data,
  input  logic         i_hit,    // this channel is the target this cycle
  output logic [W-1:0] o_data,
  output logic         o_valid
);

  logic [W-1:0] r_data;
  logic         r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_hit;
      if (i_hit)
        r_data <= i_data;
      else if (!HOLD)
        r_data <= '0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

module demux_1to2_reg #(
  parameter int unsigned bit_width  = 8,
  parameter bit          HOLD_UNSEL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [bit_width-1:0] i,
  input  logic                 sel,
  input  logic                 in_valid,
  output logic [bit_width-1:0] out_a,
  output logic [bit_width-1:0] out_b,
  output logic                 valid_a,
  output logic                 valid_b
);

  localparam int unsigned NUM_CH = 2;

  // Channel 0 is A, channel 1 is B. Hits are one-hot or zero by
  // construction, so the two valid strobes can never both be high.
  logic [NUM_CH-1:0]                w_hit;
  logic [NUM_CH-1:0][bit_width-1:0] w_data;
  logic [NUM_CH-1:0]                w_valid;

  assign w_hit[0] = in_valid & ~sel;
  assign w_hit[1] = in_valid &  sel;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    demux_1to2_reg_chan #(
      .W    (bit_width),
      .HOLD (HOLD_UNSEL)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .i_data  (i),
      .i_hit   (w_hit[ch]),
      .o_data  (w_data[ch]),
      .o_valid (w_valid[ch])
    );
  end

  assign out_a   = w_data[0];
  assign out_b   = w_data[1];
  assign valid_a = w_valid[0];
  assign valid_b = w_valid[1];

endmodule

// File: tb/tb_demux_1to2_reg.sv
// ---------------------------------------------------------------------------
// tb_demux_1to2_reg
//   Drives two instances (HOLD_UNSEL=0 and HOLD_UNSEL=1) with identical
//   stimulus and compares both against a per-mode reference of the outputs.
// ---------------------------------------------------------------------------
module tb_demux_1to2_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i = '0;
  logic       sel = 1'b0;
  logic       in_valid = 1'b0;

  logic [7:0] out_a0, out_b0, out_a1, out_b1;
  logic       valid_a0, valid_b0, valid_a1, valid_b1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: index 0 = clear-unselected mode, index 1 = hold mode.
  logic [7:0] m_a [2];
  logic [7:0] m_b [2];
  logic       m_va, m_vb;

  always #5 clk = ~clk;

  demux_1to2_reg #(.bit_width(8), .HOLD_UNSEL(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .i(i), .sel(sel), .in_valid(in_valid),
    .out_a(out_a0), .out_b(out_b0), .valid_a(valid_a0), .valid_b(valid_b0)
  );

  demux_1to2_reg #(.bit_width(8), .HOLD_UNSEL(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .i(i), .sel(sel), .in_valid(in_valid),
    .out_a(out_a1), .out_b(out_b1), .valid_a(valid_a1), .valid_b(valid_b1)
  );

  logic [35:0] obs, expv;
  assign obs  = {out_a0, out_b0, valid_a0, valid_b0, out_a1, out_b1, valid_a1, valid_b1};
  assign expv = {m_a[0], m_b[0], m_va, m_vb, m_a[1], m_b[1], m_va, m_vb};

  // Apply one cycle of inputs, let the edge happen, advance the reference
  // from the behavioural rules, then settle 1 time unit past the edge.
  task automatic drive(input logic r, input logic [7:0] d, input logic s, input logic v);
    rst = r; i = d; sel = s; in_valid = v;
    @(posedge clk);
    for (int h = 0; h < 2; h++) begin
      if (r) begin
        m_a[h] = 8'h00; m_b[h] = 8'h00;
      end else if (v && !s) begin
        m_a[h] = d;
        if (h == 0) m_b[h] = 8'h00;
      end else if (v && s) begin
        m_b[h] = d;
        if (h == 0) m_a[h] = 8'h00;
      end else if (h == 0) begin
        m_a[h] = 8'h00; m_b[h] = 8'h00;
      end
    end
    m_va = !r && v && !s;
    m_vb = !r && v &&  s;
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 8'h10, 1'b1, 1'b1);
      n_cmp++;
      if (obs !== 36'h0) begin
        n_err++;
        $display("FAIL reset[%0d]: got %h want %h", k, obs, 36'h0);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] want_b1;
    // Routing to B, then B again, then A.
    drive(1'b0, 8'h10, 1'b1, 1'b1);
    n_cmp++;
    if (out_b0 !== 8'h10 || valid_b0 !== 1'b1 || out_a0 !== 8'h00 || valid_a0 !== 1'b0) begin
      n_err++;
      $display("FAIL basic_to_b: got a=%h va=%b b=%h vb=%b want a=00 va=0 b=10 vb=1",
               out_a0, valid_a0, out_b0, valid_b0);
    end
    drive(1'b0, 8'h20, 1'b1, 1'b1);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL basic_b_again: got %h want %h", obs, expv);
    end
    drive(1'b0, 8'h20, 1'b0, 1'b1);
    n_cmp++;
    if (out_a0 !== 8'h20 || out_b0 !== 8'h00 || out_a1 !== 8'h20 || out_b1 !== 8'h20 ||
        valid_a0 !== 1'b1 || valid_b0 !== 1'b0) begin
      n_err++;
      $display("FAIL basic_to_a: got a0=%h b0=%h a1=%h b1=%h va=%b vb=%b want 20 00 20 20 1 0",
               out_a0, out_b0, out_a1, out_b1, valid_a0, valid_b0);
    end
    // Idle cycle with junk data: clear mode zeroes, hold mode keeps.
    drive(1'b0, 8'hFF, 1'b0, 1'b0);
    want_b1 = 8'h20;
    n_cmp++;
    if (obs !== expv || out_b1 !== want_b1 || out_a0 !== 8'h00) begin
      n_err++;
      $display("FAIL basic_idle: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_alternate();
    logic [7:0] words [4];
    words[0] = 8'hA1; words[1] = 8'hB2; words[2] = 8'hC3; words[3] = 8'hD4;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, words[k], k[0], 1'b1);
      n_cmp++;
      if (obs !== expv || (valid_a0 && valid_b0)) begin
        n_err++;
        $display("FAIL alternate[%0d]: got %h want %h", k, obs, expv);
      end
    end
  endtask

  task automatic test_midreset();
    drive(1'b0, 8'hA1, 1'b0, 1'b1);
    drive(1'b0, 8'hB2, 1'b1, 1'b1);
    drive(1'b1, 8'hC3, 1'b0, 1'b1);
    n_cmp++;
    if (obs !== 36'h0) begin
      n_err++;
      $display("FAIL midreset_clear: got %h want %h", obs, 36'h0);
    end
    drive(1'b0, 8'hC3, 1'b0, 1'b1);
    n_cmp++;
    if (obs !== expv || out_a1 !== 8'hC3 || out_b1 !== 8'h00) begin
      n_err++;
      $display("FAIL midreset_resume_a: got %h want %h", obs, expv);
    end
    drive(1'b0, 8'hD4, 1'b1, 1'b1);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL midreset_resume_b: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_random();
    logic       r, s, v;
    logic [7:0] d;
    for (int k = 0; k < 300; k++) begin
      r = ($urandom_range(0, 15) == 0);
      s = $urandom_range(0, 1);
      v = ($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      drive(r, d, s, v);
      n_cmp++;
      if (obs !== expv || (valid_a0 && valid_b0) || (valid_a1 && valid_b1)) begin
        n_err++;
        $display("FAIL random[%0d]: got %h want %h (rst=%b sel=%b vld=%b i=%h)",
                 k, obs, expv, r, s, v, d);
      end
    end
  endtask

  initial begin
    m_a[0] = 8'h00; m_a[1] = 8'h00; m_b[0] = 8'h00; m_b[1] = 8'h00;
    m_va = 1'b0; m_vb = 1'b0;
    test_reset();
    test_basic();
    test_alternate();
    test_midreset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
